xif_result_arbiter: RTL and testbench

//  Shares the single CORE-V-XIF result channel between NUM_SRC FPU result producers (FMA pipe, div/sqrt, FP load).

---
 rtl/xif_result_arbiter.sv | 135 +++++++++++++
 tb/tb_xif_result_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xif_result_arbiter.sv
// Shares one CORE-V-XIF result channel between NUM_SRC FPU result producers.
// Results are released only once their id is committed; killed ids are drained silently.
module xif_result_arbiter #(
    parameter int NUM_SRC     = 3,
    parameter int X_ID_WIDTH  = 4,
    parameter int XLEN        = 32,
    parameter int X_RFW_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_SRC-1:0]             src_valid,
    output logic [NUM_SRC-1:0]             src_ready,
    input  logic [NUM_SRC*X_ID_WIDTH-1:0]  src_id,
    input  logic [NUM_SRC*XLEN-1:0]        src_data,
    input  logic [NUM_SRC*5-1:0]           src_rd,
    input  logic [NUM_SRC-1:0]             src_we,
    input  logic [NUM_SRC-1:0]             src_exc,
    input  logic [NUM_SRC*6-1:0]           src_exccode,
    input  logic                           commit_valid,
    input  logic [X_ID_WIDTH-1:0]          commit_id,
    input  logic                           commit_kill,
    output logic                           result_valid,
    input  logic                           result_ready,
    output logic [X_ID_WIDTH-1:0]          result_id,
    output logic [X_RFW_WIDTH-1:0]         result_data,
    output logic [4:0]                     result_rd,
    output logic                           result_we,
    output logic                           result_exc,
    output logic [5:0]                     result_exccode
);

    localparam int DEPTH = 1 << X_ID_WIDTH;
    localparam int PW    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [DEPTH-1:0]      committed;
    logic [DEPTH-1:0]      killed;
    logic [PW-1:0]         rr;
    logic [X_ID_WIDTH-1:0] id [NUM_SRC];
    logic [NUM_SRC-1:0]    drain;
    logic [NUM_SRC-1:0]    elig;
    logic [NUM_SRC-1:0]    gnt_onehot;
    logic                  gnt_vld;
    logic [PW-1:0]         gnt_idx;
    logic                  out_free;

    assign out_free = !result_valid || result_ready;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            id[i]    = src_id[i*X_ID_WIDTH +: X_ID_WIDTH];
            drain[i] = src_valid[i] & committed[id[i]] & killed[id[i]];
            elig[i]  = src_valid[i] & committed[id[i]] & !killed[id[i]];
        end
    end

    // Round-robin: first eligible source at or after rr, wrapping.
    always_comb begin
        int j;
        j          = 0;
        gnt_vld    = 1'b0;
        gnt_idx    = '0;
        gnt_onehot = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            j = (int'(rr) + k) % NUM_SRC;
            if (!gnt_vld && elig[j]) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'(j);
            end
        end
        if (!out_free) gnt_vld = 1'b0;
        if (gnt_vld) gnt_onehot[gnt_idx] = 1'b1;
    end

    assign src_ready = drain | gnt_onehot;

    // Release clears are applied first so a same-cycle commit of that id wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            committed <= '0;
            killed    <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (drain[i]) begin
                    committed[id[i]] <= 1'b0;
                    killed[id[i]]    <= 1'b0;
                end
            end
            if (gnt_vld) committed[id[gnt_idx]] <= 1'b0;
            if (commit_valid) begin
                committed[commit_id] <= 1'b1;
                killed[commit_id]    <= commit_kill;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_valid   <= 1'b0;
            result_id      <= '0;
            result_data    <= '0;
            result_rd      <= '0;
            result_we      <= 1'b0;
            result_exc     <= 1'b0;
            result_exccode <= '0;
            rr             <= '0;
        end else if (gnt_vld) begin
            result_valid   <= 1'b1;
            result_id      <= id[gnt_idx];
            result_data    <= src_data[gnt_idx*XLEN +: XLEN];
            result_rd      <= src_rd[gnt_idx*5 +: 5];
            result_we      <= src_we[gnt_idx];
            result_exc     <= src_exc[gnt_idx];
            result_exccode <= src_exccode[gnt_idx*6 +: 6];
            rr             <= PW'((int'(gnt_idx) + 1) % NUM_SRC);
        end else if (result_ready) begin
            result_valid   <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            if (commit_valid)
                assert (!committed[commit_id])
                    else $error("commit for id %0d already committed", commit_id);
            for (int a = 0; a < NUM_SRC; a++)
                for (int b = a + 1; b < NUM_SRC; b++)
                    if (src_valid[a] && src_valid[b])
                        assert (id[a] != id[b])
                            else $error("sources %0d and %0d present same id %0d", a, b, id[a]);
        end
    end
`endif

endmodule

// File: tb/tb_xif_result_arbiter.sv
// Directed bench for xif_result_arbiter: expected results are queued at issue time
// and a negedge monitor pops and compares on every result handshake.
module tb_xif_result_arbiter;

    localparam int NS = 3;
    localparam int IW = 4;
    localparam int XL = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NS-1:0]   src_valid;
    logic [NS-1:0]   src_ready;
    logic [NS*IW-1:0] src_id;
    logic [NS*XL-1:0] src_data;
    logic [NS*5-1:0] src_rd;
    logic [NS-1:0]   src_we;
    logic [NS-1:0]   src_exc;
    logic [NS*6-1:0] src_exccode;
    logic            commit_valid;
    logic [IW-1:0]   commit_id;
    logic            commit_kill;
    logic            result_valid;
    logic            result_ready;
    logic [IW-1:0]   result_id;
    logic [XL-1:0]   result_data;
    logic [4:0]      result_rd;
    logic            result_we;
    logic            result_exc;
    logic [5:0]      result_exccode;

    xif_result_arbiter #(.NUM_SRC(NS), .X_ID_WIDTH(IW), .XLEN(XL), .X_RFW_WIDTH(XL)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_valid(src_valid), .src_ready(src_ready), .src_id(src_id),
        .src_data(src_data), .src_rd(src_rd), .src_we(src_we),
        .src_exc(src_exc), .src_exccode(src_exccode),
        .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_id(result_id), .result_data(result_data), .result_rd(result_rd),
        .result_we(result_we), .result_exc(result_exc), .result_exccode(result_exccode)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [XL-1:0] data;
        logic [4:0]    rd;
        logic          we;
        logic          exc;
        logic [5:0]    code;
    } res_t;

    res_t q[$];
    res_t mon_act, mon_exp;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [IW-1:0] id, input logic [XL-1:0] d,
                           input logic [4:0] rd, input logic we, input logic exc,
                           input logic [5:0] code);
        src_valid[i]          = 1'b1;
        src_id[i*IW +: IW]    = id;
        src_data[i*XL +: XL]  = d;
        src_rd[i*5 +: 5]      = rd;
        src_we[i]             = we;
        src_exc[i]            = exc;
        src_exccode[i*6 +: 6] = code;
    endtask

    task automatic clr_src(input int i);
        src_valid[i] = 1'b0;
    endtask

    task automatic push(input logic [IW-1:0] id, input logic [XL-1:0] d, input logic [4:0] rd,
                        input logic we, input logic exc, input logic [5:0] code);
        q.push_back('{id: id, data: d, rd: rd, we: we, exc: exc, code: code});
    endtask

    // One-cycle commit pulse issued in the current cycle; caller drops it next tick.
    task automatic commit(input logic [IW-1:0] id, input logic kill);
        commit_valid = 1'b1;
        commit_id    = id;
        commit_kill  = kill;
    endtask

    always @(negedge clk) begin
        if (rst_n && result_valid && result_ready) begin
            mon_act = '{id: result_id, data: result_data, rd: result_rd, we: result_we,
                        exc: result_exc, code: result_exccode};
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon_unexpected: got result id %0d, want none", result_id);
            end else begin
                mon_exp = q.pop_front();
                check("mon_result", 64'(mon_act), 64'(mon_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; result_ready = 1'b0;
        src_valid = '0; src_id = '0; src_data = '0; src_rd = '0;
        src_we = '0; src_exc = '0; src_exccode = '0;
        commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(result_valid), 0);
        check("rst_ready", 64'(src_ready), 0);
        check("rst_fields", 64'({result_id, result_data, result_rd, result_we, result_exc, result_exccode}), 0);
        tick(); rst_n = 1'b1;

        // basic: commit id5, then present it
        tick(); commit(5, 0); result_ready = 1'b1;
        tick(); commit_valid = 1'b0;
        set_src(0, 5, 32'h3F80_0000, 7, 1, 0, 0); push(5, 32'h3F80_0000, 7, 1, 0, 0);
        @(negedge clk); check("t2_src_ready", 64'(src_ready), 64'b001);
        tick(); clr_src(0);
        @(negedge clk); check("t2_result_valid", 64'(result_valid), 1);
        tick();
        @(negedge clk); check("t2_empty_drop", 64'(result_valid), 0);

        // kill: id2 drained with no output, then reused normally on src2
        tick(); commit(2, 1);
        tick(); commit_valid = 1'b0; set_src(1, 2, 32'hDEAD_0002, 3, 1, 0, 0);
        @(negedge clk); check("t3_drain_ready", 64'(src_ready), 64'b010);
        tick(); clr_src(1);
        @(negedge clk); check("t3_no_result", 64'(result_valid), 0);
        tick();
        @(negedge clk); check("t3_no_result2", 64'(result_valid), 0);
        tick(); commit(2, 0);
        tick(); commit_valid = 1'b0;
        set_src(2, 2, 32'hAAAA_0002, 2, 1, 0, 0); push(2, 32'hAAAA_0002, 2, 1, 0, 0);
        @(negedge clk); check("t3_reuse_ready", 64'(src_ready), 64'b100);
        tick(); clr_src(2);
        @(negedge clk); check("t3_reuse_valid", 64'(result_valid), 1);

        // round-robin: ids 1,2,3 then re-presented src0 id8 after src2
        tick(); commit(1, 0);
        tick(); commit(2, 0);
        tick(); commit(3, 0);
        tick(); commit(8, 0);
        tick(); commit_valid = 1'b0;
        set_src(0, 1, 32'h0000_0011, 1, 1, 0, 0);
        set_src(1, 2, 32'h0000_0022, 2, 1, 0, 0);
        set_src(2, 3, 32'h0000_0033, 3, 1, 0, 0);
        push(1, 32'h0000_0011, 1, 1, 0, 0);
        push(2, 32'h0000_0022, 2, 1, 0, 0);
        push(3, 32'h0000_0033, 3, 1, 0, 0);
        push(8, 32'h0000_0088, 8, 1, 0, 0);
        @(negedge clk); check("t4_gnt_src0", 64'(src_ready), 64'b001);
        tick(); set_src(0, 8, 32'h0000_0088, 8, 1, 0, 0);
        @(negedge clk); check("t4_gnt_src1", 64'(src_ready), 64'b010);
        check("t4_valid_b", 64'(result_valid), 1);
        tick(); clr_src(1);
        @(negedge clk); check("t4_gnt_src2", 64'(src_ready), 64'b100);
        check("t4_valid_c", 64'(result_valid), 1);
        tick(); clr_src(2);
        @(negedge clk); check("t4_gnt_src0_again", 64'(src_ready), 64'b001);
        check("t4_valid_d", 64'(result_valid), 1);
        tick(); clr_src(0);
        @(negedge clk); check("t4_valid_e", 64'(result_valid), 1);

        // backpressure: id9 held four cycles, then handshake with same-cycle grant of id10
        tick(); commit(9, 0);
        tick(); commit(10, 0);
        tick(); commit_valid = 1'b0; result_ready = 1'b0;
        set_src(1, 9, 32'h0000_0099, 9, 1, 0, 0);
        push(9, 32'h0000_0099, 9, 1, 0, 0);
        push(10, 32'h0000_00A0, 10, 1, 0, 0);
        @(negedge clk); check("t5_first_gnt", 64'(src_ready), 64'b010);
        tick(); clr_src(1); set_src(2, 10, 32'h0000_00A0, 10, 1, 0, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t5_hold_ready", 64'(src_ready), 0);
            check("t5_hold_fields", 64'({result_valid, result_id, result_data, result_rd}),
                  64'({1'b1, 4'd9, 32'h0000_0099, 5'd9}));
            tick();
        end
        result_ready = 1'b1;
        @(negedge clk); check("t5_release_gnt", 64'(src_ready), 64'b100);
        tick(); clr_src(2);
        @(negedge clk); check("t5_no_bubble", 64'(result_valid), 1);
        tick();

        // simultaneous drain (src2 id4 killed) and grant (src0 id6, with exception)
        tick(); commit(4, 1);
        tick(); commit(6, 0);
        tick(); commit_valid = 1'b0;
        set_src(2, 4, 32'h0000_0444, 4, 1, 0, 0);
        set_src(0, 6, 32'h0000_0666, 6, 0, 1, 6'h0D);
        push(6, 32'h0000_0666, 6, 0, 1, 6'h0D);
        @(negedge clk); check("t6_both_ready", 64'(src_ready), 64'b101);
        tick(); clr_src(0); clr_src(2);
        @(negedge clk); check("t6_valid", 64'(result_valid), 1);
        tick();
        @(negedge clk); check("t6_only_one", 64'(result_valid), 0);

        // reset while a result is held; table must come back empty
        tick(); commit(11, 0); result_ready = 1'b0;
        tick(); commit(12, 0);
        tick(); commit_valid = 1'b0; set_src(0, 11, 32'h0000_0BBB, 11, 1, 0, 0);
        @(negedge clk); check("t1_pre_gnt", 64'(src_ready), 64'b001);
        tick(); clr_src(0);
        @(negedge clk); check("t1_held", 64'(result_valid), 1);
        #2 rst_n = 1'b0;
        #1 check("t1_async_drop", 64'(result_valid), 0);
        check("t1_async_id", 64'(result_id), 0);
        tick(); result_ready = 1'b1;
        tick(); rst_n = 1'b1;
        tick();
        set_src(0, 3, 32'h0000_0333, 5, 1, 0, 0);
        set_src(1, 12, 32'h0000_0CCC, 12, 1, 0, 0);
        @(negedge clk); check("t1_uncommitted", 64'(src_ready), 0);
        tick();
        @(negedge clk); check("t1_uncommitted2", 64'(src_ready), 0);
        tick(); commit(3, 0);
        @(negedge clk); check("t1_commit_cycle", 64'(src_ready), 0);
        tick(); commit_valid = 1'b0; push(3, 32'h0000_0333, 5, 1, 0, 0);
        @(negedge clk); check("t1_after_commit", 64'(src_ready), 64'b001);
        tick(); clr_src(0);
        @(negedge clk); check("t1_result", 64'(result_valid), 1);
        check("t1_table_cleared", 64'(src_ready), 0);
        tick(); clr_src(1);
        tick();
        @(negedge clk); check("sb_empty", 64'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
